serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder sequencer: adds two WIDTH-bit operands one bit per cycle.
//  Datapath is a single full adder built from two halfadder instances plus an OR gate, with a registered carry.
//  The block loads the operands, steps the shared adder LSB-first, and reports a registered sum and carry-out.
//  Sits between a start/done requester and the adder primitives in the SoC arithmetic path.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range WIDTH >= 1
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      request; sampled only when not busy
//  a          in   WIDTH  operand A, captured on accepted start
//  b          in   WIDTH  operand B, captured on accepted start
//  busy       out  1      high while an addition is in progress (RUN)
//  done       out  1      one-cycle pulse: sum/carry_out valid
//  sum        out  WIDTH  registered result (a+b) mod 2^WIDTH
//  carry_out  out  1      registered carry out of bit WIDTH-1
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, sum=0, carry_out=0.
//   Carry, bit counter and shift registers are cleared.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: start=1 -> capture a,b into shift regs; clear carry and count; go to RUN.
//   start=0 -> stay in IDLE.
//  RUN, each edge:
//   - Full adder takes the shift-reg LSBs and the carry register.
//   - Sum bit is shifted into the result shift reg from the MSB side.
//   - Carry register is updated; count increments.
//   - When count reaches WIDTH-1 on this edge, all WIDTH bits are done:
//     go to DONE, load sum and carry_out from the final values.
//  DONE: done=1 for exactly this cycle.
//   start=1 -> accept a new op as in IDLE and go to RUN (back-to-back).
//   start=0 -> go to IDLE.
//  Timing: start accepted at edge E0 -> busy=1 for cycles after E0..E(WIDTH-1).
//   done=1 and new sum valid in the cycle after edge E(WIDTH).
//   Latency is WIDTH+1 edges from start to done; throughput is one op per WIDTH+1 cycles.
//  busy = (state==RUN); done = (state==DONE); both are registered-state decodes, glitch-free.
//  sum and carry_out change only on entry to DONE or on reset; they hold between ops.
//   They do not reflect partial results during RUN.
//  start while RUN: ignored, no queueing; a/b changes during RUN have no effect.
//  rst during RUN or DONE: immediate return to IDLE with all outputs at reset values.
//   The in-flight op is discarded and no done pulse is issued.
//  WIDTH=1: a single RUN cycle, then DONE; the counter still works; no zero-width vectors.
//  Counter width is $clog2(WIDTH+1); no wrap occurs inside an op.
// TESTING
//  1. rst=1 two cycles -> busy=0, done=0, sum=8'h00, carry_out=0.
//  2. start with a=8'hFF, b=8'h01 -> busy=1 for 8 cycles; done after 9 edges.
//     Expect sum=8'h00, carry_out=1.
//  3. a=8'h5A, b=8'h3C -> sum=8'h96, carry_out=0.
//     Then a=8'h00, b=8'h00 -> sum=8'h00, carry_out=0.
//  4. Pulse start (a=8'h11, b=8'h22) in cycle 3 of an 8'h5A+8'h3C op -> ignored.
//     Single done pulse; sum=8'h96.
//  5. rst in cycle 4 of an op -> IDLE next cycle, no done pulse, sum=0.
//     A fresh op then completes correctly.
//  6. Hold start high through DONE with a=8'h80, b=8'h80 -> back-to-back op.
//     Second done pulse arrives 9 edges after the first; sum=8'h00, carry_out=1.
//     Also run an exhaustive 4-bit sweep at WIDTH=4 and compare against a+b.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Handshake/bus interface for serial_adder_ctrl.
//   start      requester -> adder : request a new addition
//   a, b       requester -> adder : operands, captured on an accepted start
//   busy       adder -> requester : addition in progress
//   done       adder -> requester : one-cycle pulse, sum/carry_out valid
//   sum        adder -> requester : registered result (a+b) mod 2^WIDTH
//   carry_out  adder -> requester : registered carry out of the MSB
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   modport master (
      output start, a, b,
      input  busy, done, sum, carry_out
   );

   modport slave (
      input  start, a, b,
      output busy, done, sum, carry_out
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer.
// Adds two WIDTH-bit operands one bit per cycle, LSB first, through a single
// full adder (two half adders plus an OR) with a registered carry.
//   halfadder         : one-bit half adder primitive
//   serial_adder_ctrl : IDLE/RUN/DONE sequencer around the shared full adder
// Ports of serial_adder_ctrl:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  serial_adder_ctrl_if.slave (start, a, b in; busy, done, sum, carry_out out)

module halfadder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_adder_ctrl_if.slave   bus
);
   // Sized to hold WIDTH itself so the final increment never wraps.
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic             load;
   logic             step;
   logic             last;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] sum_hold;
   logic             cout_hold;

   logic             ha0_s;
   logic             ha0_c;
   logic             fa_sum;
   logic             ha1_c;
   logic             fa_cout;

   // Full adder: two half adders and an OR on the carries.
   halfadder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(ha0_s),  .c(ha0_c));
   halfadder u_ha1 (.x(ha0_s),   .y(carry),   .s(fa_sum), .c(ha1_c));
   assign fa_cout = ha0_c | ha1_c;

   // Result enters from the MSB side so that after WIDTH steps bit 0 sits at
   // position 0. A one-bit result has nothing to shift.
   generate
      if (WIDTH == 1) begin : g_res_one
         assign res_next = fa_sum;
      end else begin : g_res_multi
         assign res_next = {fa_sum, res_sr[WIDTH-1:1]};
      end
   endgenerate

   assign last = (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Back-to-back: a start seen during the done cycle is accepted.
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         carry     <= 1'b0;
         count     <= '0;
         sum_hold  <= '0;
         cout_hold <= 1'b0;
      end else if (load) begin
         a_sr   <= bus.a;
         b_sr   <= bus.b;
         res_sr <= '0;
         carry  <= 1'b0;
         count  <= '0;
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_next;
         carry  <= fa_cout;
         count  <= count + CNT_W'(1);
         // Outputs are only updated with the complete result.
         if (last) begin
            sum_hold  <= res_next;
            cout_hold <= fa_cout;
         end
      end
   end

   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.sum       = sum_hold;
   assign bus.carry_out = cout_hold;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 (directed vectors) and
// WIDTH=4 (full operand sweep). Expected {carry_out,sum} values are queued
// when an op is issued; monitors pop and compare on every done pulse.
module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
   serial_adder_ctrl_if #(.WIDTH(4)) if4 ();

   serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
   serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

   int         checks   = 0;
   int         failures = 0;
   int         done8_cnt = 0;
   logic [8:0] exp8_q[$];
   logic [4:0] exp4_q[$];
   logic [8:0] e8;
   logic [4:0] e4;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      if (rst === 1'b0 && if8.done === 1'b1) begin
         done8_cnt++;
         if (exp8_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done8_unexpected actual=done sum=%0h required=no_done", if8.sum);
         end else begin
            e8 = exp8_q.pop_front();
            check("result8", {23'd0, if8.carry_out, if8.sum}, {23'd0, e8});
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0 && if4.done === 1'b1) begin
         if (exp4_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done4_unexpected actual=done sum=%0h required=no_done", if4.sum);
         end else begin
            e4 = exp4_q.pop_front();
            check("result4", {27'd0, if4.carry_out, if4.sum}, {27'd0, e4});
         end
      end
   end

   // Called just after a posedge; the following posedge accepts the op.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit expect_done);
      if8.a     = a;
      if8.b     = b;
      if8.start = 1'b1;
      if (expect_done) exp8_q.push_back({1'b0, a} + {1'b0, b});
      @(posedge clk);
      #1 if8.start = 1'b0;
   endtask

   // Returns at the negedge where done is seen (or after the budget expires).
   task automatic wait_done8(output int n_edges, output int n_busy);
      bit seen = 1'b0;
      n_edges = 0;
      n_busy  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n_edges++;
         if (if8.busy) n_busy++;
         if (if8.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done8_timeout actual=no_done required=done");
      end
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b);
      int ne;
      int nb;
      issue8(a, b, 1'b1);
      wait_done8(ne, nb);
      @(posedge clk);
      #1;
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b);
      bit seen = 1'b0;
      if4.a     = a;
      if4.b     = b;
      if4.start = 1'b1;
      exp4_q.push_back({1'b0, a} + {1'b0, b});
      @(posedge clk);
      #1 if4.start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if4.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done4_timeout actual=no_done required=done a=%0h b=%0h", a, b);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ne;
      int nb;
      int d0;
      rst = 1'b1;
      if8.start = 1'b0; if8.a = '0; if8.b = '0;
      if4.start = 1'b0; if4.a = '0; if4.b = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, if8.busy}, 32'd0);
      check("rst_done", {31'd0, if8.done}, 32'd0);
      check("rst_sum", {24'd0, if8.sum}, 32'd0);
      check("rst_carry", {31'd0, if8.carry_out}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // FF + 01: overflow into carry, latency and busy length
      issue8(8'hFF, 8'h01, 1'b1);
      wait_done8(ne, nb);
      check("latency_edges", ne, 32'd9);
      check("busy_cycles", nb, 32'd8);
      @(posedge clk);
      #1;
      check("idle_after_done", {30'd0, if8.busy, if8.done}, 32'd0);

      // Plain sums
      run8(8'h5A, 8'h3C);
      run8(8'h00, 8'h00);

      // Start during RUN is ignored
      d0 = done8_cnt;
      issue8(8'h5A, 8'h3C, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      if8.a = 8'h11; if8.b = 8'h22; if8.start = 1'b1;
      @(posedge clk);
      #1 if8.start = 1'b0;
      wait_done8(ne, nb);
      repeat (12) @(negedge clk);
      check("single_done", done8_cnt - d0, 32'd1);
      @(posedge clk);
      #1;

      // Reset mid-op discards it
      run8(8'h12, 8'h34);
      d0 = done8_cnt;
      issue8(8'hC3, 8'h55, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", {31'd0, if8.busy}, 32'd0);
      check("midrst_done", {31'd0, if8.done}, 32'd0);
      check("midrst_sum", {24'd0, if8.sum}, 32'd0);
      check("midrst_carry", {31'd0, if8.carry_out}, 32'd0);
      repeat (12) @(negedge clk);
      check("midrst_no_done", done8_cnt - d0, 32'd0);
      @(posedge clk);
      #1;
      run8(8'h7F, 8'h01);

      // Back-to-back with start held through DONE
      exp8_q.push_back(9'h100);
      exp8_q.push_back(9'h100);
      if8.a = 8'h80; if8.b = 8'h80; if8.start = 1'b1;
      wait_done8(ne, nb);
      @(posedge clk);
      #1 if8.start = 1'b0;
      wait_done8(ne, nb);
      check("b2b_spacing", ne, 32'd9);
      check("b2b_busy", nb, 32'd8);
      @(posedge clk);
      #1;

      // WIDTH=4 full sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run4(4'(a), 4'(b));
         end
      end

      repeat (4) @(negedge clk);
      check("queue8_empty", exp8_q.size(), 32'd0);
      check("queue4_empty", exp4_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
